// File: rtl/steering_ramp_ctrl.sv
// steering_ramp_ctrl
//   Command sequencer in front of the Steering PWM block. Slews the applied
//   duty toward the commanded target by at most STEP per ramp tick, and on a
//   direction reversal ramps to zero, holds the bridge killed for DEAD_TICKS
//   ticks, then ramps up in the new direction.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   cmd_valid  command present
//   cmd_ready  command can be accepted (accept = valid && ready at an edge)
//   cmd_duty   target duty
//   cmd_dir    target direction
//   cmd_stop   emergency stop, level sampled, beats any same-cycle command
//   mem_out    control word: [DATA_WIDTH-1]=kill, [DATA_WIDTH-2]=dir,
//              [COUNT_SIZE-1:0]=duty, all other bits zero
//   busy       state is not HALT
//   at_target  RUN with applied duty/dir equal to target duty/dir
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | bridge killed, duty 0, waiting for a non-zero command
// RUN   | bridge enabled, duty slewing toward target once per tick
// DEAD  | reversal dead time: killed, duty 0, commands refused

module steering_ramp_ctrl #(
    parameter int COUNT_SIZE = 11,
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 8,
    parameter int TICK_DIV   = 1000,
    parameter int DEAD_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COUNT_SIZE-1:0] cmd_duty,
    input  logic                  cmd_dir,
    input  logic                  cmd_stop,
    output logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy,
    output logic                  at_target
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]       DEAD_LAST  = DW'(DEAD_TICKS - 1);
    localparam logic [COUNT_SIZE:0] STEP_X     = (COUNT_SIZE + 1)'(STEP);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [COUNT_SIZE-1:0] cur_duty, cur_duty_n;
    logic [COUNT_SIZE-1:0] tgt_duty, tgt_duty_n;
    logic                  cur_dir, cur_dir_n;
    logic                  tgt_dir, tgt_dir_n;
    logic                  kill, kill_n;
    logic [PW-1:0]         presc;
    logic [DW-1:0]         dead_cnt, dead_cnt_n;
    logic                  tick;
    logic                  accept;

    // One extra bit so cur+STEP near full scale does not wrap before the clamp.
    logic [COUNT_SIZE:0] cur_x, tgt_x, up_x, dn_x, over_x;

    assign cur_x  = {1'b0, cur_duty};
    assign tgt_x  = {1'b0, tgt_duty};
    assign up_x   = cur_x + STEP_X;
    assign dn_x   = cur_x - STEP_X;
    assign over_x = cur_x - tgt_x;

    assign tick      = (presc == PRESC_LAST);
    assign cmd_ready = !cmd_stop && (state != S_DEAD);
    assign accept    = cmd_valid && cmd_ready;

    assign mem_out   = {kill, cur_dir, {(DATA_WIDTH - COUNT_SIZE - 2){1'b0}}, cur_duty};
    assign busy      = (state != S_HALT);
    assign at_target = (state == S_RUN) && (cur_duty == tgt_duty) && (cur_dir == tgt_dir);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_HALT;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            dead_cnt <= '0;
            cur_duty <= '0;
            tgt_duty <= '0;
            cur_dir  <= 1'b0;
            tgt_dir  <= 1'b0;
            kill     <= 1'b1;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            dead_cnt <= dead_cnt_n;
            cur_duty <= cur_duty_n;
            tgt_duty <= tgt_duty_n;
            cur_dir  <= cur_dir_n;
            tgt_dir  <= tgt_dir_n;
            kill     <= kill_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_duty_n = cur_duty;
        tgt_duty_n = tgt_duty;
        cur_dir_n  = cur_dir;
        tgt_dir_n  = tgt_dir;
        kill_n     = kill;
        dead_cnt_n = dead_cnt;

        if (cmd_stop) begin
            state_n    = S_HALT;
            kill_n     = 1'b1;
            cur_duty_n = '0;
            tgt_duty_n = '0;
        end else begin
            case (state)
                S_HALT: begin
                    kill_n     = 1'b1;
                    cur_duty_n = '0;
                    if (accept) begin
                        tgt_duty_n = cmd_duty;
                        tgt_dir_n  = cmd_dir;
                        cur_dir_n  = cmd_dir;
                        // Duty is already zero, so no dead time is needed here.
                        if (cmd_duty != '0) begin
                            kill_n  = 1'b0;
                            state_n = S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    kill_n = 1'b0;
                    // The tick works on the registered target; a command accepted
                    // on the same edge is picked up by the following tick.
                    if (tick) begin
                        if (cur_dir != tgt_dir) begin
                            if (cur_duty == '0) begin
                                kill_n = 1'b1;
                                if (tgt_duty != '0) begin
                                    dead_cnt_n = '0;
                                    state_n    = S_DEAD;
                                end else begin
                                    cur_dir_n = tgt_dir;
                                    state_n   = S_HALT;
                                end
                            end else if (cur_x <= STEP_X) begin
                                cur_duty_n = '0;
                            end else begin
                                cur_duty_n = dn_x[COUNT_SIZE-1:0];
                            end
                        end else if (cur_duty == '0 && tgt_duty == '0) begin
                            kill_n  = 1'b1;
                            state_n = S_HALT;
                        end else if (cur_x < tgt_x) begin
                            cur_duty_n = (up_x >= tgt_x) ? tgt_duty : up_x[COUNT_SIZE-1:0];
                        end else if (cur_x > tgt_x) begin
                            cur_duty_n = (over_x <= STEP_X) ? tgt_duty : dn_x[COUNT_SIZE-1:0];
                        end
                    end
                    if (accept) begin
                        tgt_duty_n = cmd_duty;
                        tgt_dir_n  = cmd_dir;
                    end
                end

                S_DEAD: begin
                    kill_n     = 1'b1;
                    cur_duty_n = '0;
                    if (tick) begin
                        if (dead_cnt == DEAD_LAST) begin
                            dead_cnt_n = '0;
                            cur_dir_n  = tgt_dir;
                            kill_n     = 1'b0;
                            state_n    = S_RUN;
                        end else begin
                            dead_cnt_n = dead_cnt + DW'(1);
                        end
                    end
                end

                default: begin
                    state_n    = S_HALT;
                    kill_n     = 1'b1;
                    cur_duty_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steering_ramp_ctrl.sv
module tb_steering_ramp_ctrl;

    localparam int CS  = 11;
    localparam int DWD = 32;
    localparam int STP = 8;
    localparam int TD  = 4;
    localparam int DT  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [CS-1:0]  cmd_duty = '0;
    logic           cmd_dir = 1'b0;
    logic           cmd_stop = 1'b0;
    logic [DWD-1:0] mem_out;
    logic           busy;
    logic           at_target;

    int total = 0;
    int bad   = 0;

    steering_ramp_ctrl #(
        .COUNT_SIZE(CS), .DATA_WIDTH(DWD), .STEP(STP), .TICK_DIV(TD), .DEAD_TICKS(DT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .cmd_stop(cmd_stop),
        .mem_out(mem_out), .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    // Reference model: duty as a plain integer, "halted" flag and a count of
    // dead-time ticks still to serve.
    int m_phase = 0;
    int m_duty = 0;
    int m_tgt = 0;
    int m_dead_left = 0;
    bit m_dir = 1'b0;
    bit m_tdir = 1'b0;
    bit m_halt = 1'b1;

    task automatic model_update();
        bit tick;
        int d;
        tick = (m_phase == TD - 1);
        if (!rst) begin
            m_phase = 0; m_duty = 0; m_tgt = 0; m_dead_left = 0;
            m_dir = 1'b0; m_tdir = 1'b0; m_halt = 1'b1;
            return;
        end
        m_phase = tick ? 0 : m_phase + 1;
        if (cmd_stop) begin
            m_halt = 1'b1; m_dead_left = 0; m_duty = 0; m_tgt = 0;
        end else if (m_dead_left > 0) begin
            if (tick) begin
                m_dead_left--;
                if (m_dead_left == 0) m_dir = m_tdir;
            end
        end else if (m_halt) begin
            if (cmd_valid) begin
                m_tgt = int'(cmd_duty); m_tdir = cmd_dir; m_dir = cmd_dir;
                if (m_tgt > 0) m_halt = 1'b0;
            end
        end else begin
            if (tick) begin
                if (m_dir != m_tdir) begin
                    if (m_duty == 0) begin
                        if (m_tgt > 0) m_dead_left = DT;
                        else begin m_dir = m_tdir; m_halt = 1'b1; end
                    end else begin
                        m_duty = (m_duty > STP) ? m_duty - STP : 0;
                    end
                end else if (m_duty == 0 && m_tgt == 0) begin
                    m_halt = 1'b1;
                end else begin
                    d = m_tgt - m_duty;
                    if (d > STP) d = STP;
                    if (d < -STP) d = -STP;
                    m_duty = m_duty + d;
                end
            end
            if (cmd_valid) begin
                m_tgt = int'(cmd_duty); m_tdir = cmd_dir;
            end
        end
    endtask

    function automatic logic [31:0] exp_mem();
        logic [31:0] e;
        e = '0;
        e[31] = m_halt || (m_dead_left > 0);
        e[30] = m_dir;
        e[10:0] = 11'(m_duty);
        return e;
    endfunction

    function automatic logic exp_at();
        return !m_halt && (m_dead_left == 0) && (m_duty == m_tgt) && (m_dir == m_tdir);
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to_tick();
        bit t;
        do begin
            t = (m_phase == TD - 1);
            step();
        end while (!t);
    endtask

    task automatic send(int duty, bit dir);
        cmd_valid = 1'b1;
        cmd_duty  = CS'(duty);
        cmd_dir   = dir;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        total++; if (mem_out !== 32'h8000_0000) begin bad++; $display("FAIL reset_mem: got %h want %h", mem_out, 32'h8000_0000); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (at_target !== 1'b0) begin bad++; $display("FAIL reset_at_target: got %b want 0", at_target); end
    endtask

    task automatic test_ramp_up(string tag);
        int exp_d[3] = '{8, 16, 20};
        logic [31:0] w;
        send(20, 1'b1);
        total++; if (mem_out !== 32'h4000_0000) begin bad++; $display("FAIL %s_accept: got %h want %h", tag, mem_out, 32'h4000_0000); end
        for (int i = 0; i < 3; i++) begin
            step_to_tick();
            w = 32'h4000_0000 | 32'(exp_d[i]);
            total++; if (mem_out !== w) begin bad++; $display("FAIL %s_tick%0d: got %h want %h", tag, i, mem_out, w); end
            total++; if (at_target !== (i == 2)) begin bad++; $display("FAIL %s_at_target%0d: got %b want %b", tag, i, at_target, (i == 2)); end
        end
    endtask

    task automatic test_reversal();
        int dn[3] = '{12, 4, 0};
        int up[2] = '{8, 16};
        logic [31:0] w;
        send(16, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_to_tick();
            w = 32'h4000_0000 | 32'(dn[i]);
            total++; if (mem_out !== w) begin bad++; $display("FAIL rev_down%0d: got %h want %h", i, mem_out, w); end
        end
        for (int i = 0; i < 2; i++) begin
            step_to_tick();
            total++; if (mem_out !== 32'hC000_0000) begin bad++; $display("FAIL rev_dead%0d: got %h want %h", i, mem_out, 32'hC000_0000); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rev_dead_ready%0d: got %b want 0", i, cmd_ready); end
        end
        step_to_tick();
        total++; if (mem_out !== 32'h0000_0000) begin bad++; $display("FAIL rev_release: got %h want %h", mem_out, 32'h0); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rev_release_ready: got %b want 1", cmd_ready); end
        for (int i = 0; i < 2; i++) begin
            step_to_tick();
            total++; if (mem_out !== 32'(up[i])) begin bad++; $display("FAIL rev_up%0d: got %h want %h", i, mem_out, 32'(up[i])); end
        end
        total++; if (at_target !== 1'b1) begin bad++; $display("FAIL rev_at_target: got %b want 1", at_target); end
    endtask

    task automatic test_retarget();
        int up[4] = '{24, 32, 40, 48};
        send(100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step_to_tick();
            total++; if (mem_out !== 32'(up[i])) begin bad++; $display("FAIL retgt_up%0d: got %h want %h", i, mem_out, 32'(up[i])); end
        end
        send(40, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step_to_tick();
            total++; if (mem_out !== 32'd40) begin bad++; $display("FAIL retgt_hold%0d: got %h want %h", i, mem_out, 32'd40); end
            total++; if (at_target !== 1'b1) begin bad++; $display("FAIL retgt_at%0d: got %b want 1", i, at_target); end
        end
    endtask

    task automatic test_stop();
        send(0, 1'b0);
        step_to_tick();
        step_to_tick();
        total++; if (mem_out !== 32'd24) begin bad++; $display("FAIL stop_pre: got %h want %h", mem_out, 32'd24); end
        cmd_stop = 1'b1; cmd_valid = 1'b1; cmd_duty = 11'd50; cmd_dir = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL stop_ready: got %b want 0", cmd_ready); end
        step();
        cmd_stop = 1'b0; cmd_valid = 1'b0;
        total++; if (mem_out !== 32'h8000_0000) begin bad++; $display("FAIL stop_mem: got %h want %h", mem_out, 32'h8000_0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b want 0", busy); end
        repeat (6) step();
        total++; if (mem_out !== 32'h8000_0000) begin bad++; $display("FAIL stop_noaccept: got %h want %h", mem_out, 32'h8000_0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy_late: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_dead();
        send(8, 1'b1);
        step_to_tick();
        total++; if (mem_out !== 32'h4000_0008) begin bad++; $display("FAIL rmd_up: got %h want %h", mem_out, 32'h4000_0008); end
        send(8, 1'b0);
        step_to_tick();
        step_to_tick();
        total++; if (mem_out !== 32'hC000_0000) begin bad++; $display("FAIL rmd_dead: got %h want %h", mem_out, 32'hC000_0000); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmd_busy: got %b want 1", busy); end
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (mem_out !== 32'h8000_0000) begin bad++; $display("FAIL rmd_rst_mem: got %h want %h", mem_out, 32'h8000_0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmd_rst_busy: got %b want 0", busy); end
        total++; if (at_target !== 1'b0) begin bad++; $display("FAIL rmd_rst_at: got %b want 0", at_target); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmd_rst_ready: got %b want 1", cmd_ready); end
        test_ramp_up("rmd_ramp");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 30);
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_duty  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 40));
            cmd_stop  = ($urandom_range(0, 199) == 0);
            rst       = ($urandom_range(0, 499) != 0);
            #1;
            total++; if (cmd_ready !== (!cmd_stop && m_dead_left == 0)) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", i, cmd_ready, (!cmd_stop && m_dead_left == 0)); end
            step();
            total++; if (mem_out !== exp_mem()) begin bad++; $display("FAIL rnd_mem@%0d: got %h want %h", i, mem_out, exp_mem()); end
            total++; if (busy !== !m_halt) begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, !m_halt); end
            total++; if (at_target !== exp_at()) begin bad++; $display("FAIL rnd_at@%0d: got %b want %b", i, at_target, exp_at()); end
        end
        cmd_valid = 1'b0; cmd_stop = 1'b0; rst = 1'b1;
    endtask

    task automatic test_full_scale();
        bit done = 1'b0;
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        send(2047, 1'b1);
        for (int i = 0; i < 1200 && !done; i++) begin
            step();
            total++; if (mem_out !== exp_mem()) begin bad++; $display("FAIL full_ramp@%0d: got %h want %h", i, mem_out, exp_mem()); end
            done = exp_at();
        end
        total++; if (!done) begin bad++; $display("FAIL full_timeout: model never reached target, duty now %0d want 2047", m_duty); end
        total++; if (mem_out !== 32'h4000_07FF || at_target !== 1'b1) begin bad++; $display("FAIL full_top: got %h/%b want %h/1", mem_out, at_target, 32'h4000_07FF); end
        send(2040, 1'b1);
        step_to_tick();
        total++; if (mem_out !== 32'h4000_07F8) begin bad++; $display("FAIL full_down7: got %h want %h", mem_out, 32'h4000_07F8); end
        send(2047, 1'b1);
        step_to_tick();
        total++; if (mem_out !== 32'h4000_07FF) begin bad++; $display("FAIL full_up7: got %h want %h", mem_out, 32'h4000_07FF); end
    endtask

    initial begin
        test_reset();
        test_ramp_up("ramp");
        test_reversal();
        test_retarget();
        test_stop();
        test_reset_mid_dead();
        test_random();
        test_full_scale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
